// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, D-stage branch/jump redirects (held across stallF), exception redirects.
// Optional misaligned-PC flag enabled by defining PC_ADDR_ERR_CHECK_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        isBranchNeeded,
  input  logic        isJumpToReg,
  input  logic [31:0] instrD,
  input  logic [31:0] pcplus4D,
  input  logic [31:0] rsValueD,
  input  logic        excFlush,
  input  logic [31:0] excPC,
  output logic [31:0] pcF,
  output logic        redirectPending,
  output logic        isInDelaySlotD,
  output logic        pcAddrErrF
);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        ds_q, ds_d;

  logic [5:0]  op, funct;
  logic        is_branch, is_jump, is_jreg, is_ctrl;
  logic [31:0] br_target, j_target, target;
  logic        redirectD;

  assign op    = instrD[31:26];
  assign funct = instrD[5:0];

  assign is_branch = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000110) ||
                     (op == 6'b000111) || (op == 6'b000001);
  assign is_jump   = (op == 6'b000010) || (op == 6'b000011);
  assign is_jreg   = (op == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001));
  assign is_ctrl   = is_branch || is_jump || is_jreg;

  assign br_target = pcplus4D + {{14{instrD[15]}}, instrD[15:0], 2'b00};
  assign j_target  = {pcplus4D[31:28], instrD[25:0], 2'b00};
  assign target    = isJumpToReg ? rsValueD : (is_jump ? j_target : br_target);

  assign redirectD = !stallD && (isBranchNeeded || is_jump || isJumpToReg);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ds_d    = ds_q;

    if (excFlush) begin
      pc_d    = excPC;
      state_d = IDLE;
      pend_d  = '0;
    end else if (state_q == PENDING) begin
      // New redirects are dropped while one is already held.
      if (!stallF) begin
        pc_d    = pend_q;
        state_d = IDLE;
      end
    end else if (redirectD) begin
      if (!stallF) begin
        pc_d = target;
      end else begin
        pend_d  = target;
        state_d = PENDING;
      end
    end else if (!stallF) begin
      pc_d = pc_q + PC_STEP;
    end

    if (excFlush) begin
      ds_d = 1'b0;
    end else if (!stallD) begin
      ds_d = is_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ds_q    <= ds_d;
    end
  end

  assign pcF             = pc_q;
  assign redirectPending = (state_q == PENDING);
  assign isInDelaySlotD  = ds_q;

`ifdef PC_ADDR_ERR_CHECK_EN
  logic err_q;

  // Tracks pc_d so the flag changes on the same edge as pcF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (pc_d[1:0] != 2'b00);
    end
  end

  assign pcAddrErrF = err_q;
`else
  assign pcAddrErrF = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, isBranchNeeded, isJumpToReg, excFlush;
  logic [31:0] instrD, pcplus4D, rsValueD, excPC;
  logic [31:0] pcF;
  logic        redirectPending, isInDelaySlotD, pcAddrErrF;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: a queue holds at most one waiting redirect target.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ds;
  logic        m_err;

  pc_redirect_ctrl #(.RESET_PC(32'hBFC00000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .isBranchNeeded(isBranchNeeded), .isJumpToReg(isJumpToReg),
    .instrD(instrD), .pcplus4D(pcplus4D), .rsValueD(rsValueD),
    .excFlush(excFlush), .excPC(excPC), .pcF(pcF),
    .redirectPending(redirectPending), .isInDelaySlotD(isInDelaySlotD),
    .pcAddrErrF(pcAddrErrF)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stallF = 0; stallD = 0; isBranchNeeded = 0; isJumpToReg = 0; excFlush = 0;
    instrD = 32'h0; pcplus4D = 32'h0; rsValueD = 32'h0; excPC = 32'h0;
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC00000; m_q.delete(); m_ds = 0; m_err = 0;
  endtask

  // Advances the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        br, jj, jr, redir;
    logic [31:0] tgt, off;
    op = instrD[31:26];
    fn = instrD[5:0];
    br = (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7) || (op == 6'd1);
    jj = (op == 6'd2) || (op == 6'd3);
    jr = (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
    off = 32'($signed(instrD[15:0])) * 4;
    if (jr)      tgt = rsValueD;
    else if (jj) tgt = (pcplus4D & 32'hF000_0000) | ({6'b0, instrD[25:0]} * 4);
    else         tgt = pcplus4D + off;
    redir = !stallD && (isBranchNeeded || jj || isJumpToReg);
    if (excFlush) begin
      m_pc = excPC;
      m_q.delete();
    end else if (m_q.size() != 0) begin
      if (!stallF) m_pc = m_q.pop_front();
    end else if (redir) begin
      if (!stallF) m_pc = tgt;
      else         m_q.push_back(tgt);
    end else if (!stallF) begin
      m_pc = m_pc + 4;
    end
    if (excFlush)    m_ds = 0;
    else if (!stallD) m_ds = br || jj || jr;
`ifdef PC_ADDR_ERR_CHECK_EN
    m_err = (m_pc % 4) != 0;
`else
    m_err = 0;
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    model_reset();
    #2;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    model_edge();  // the edge just taken advanced the sequential PC once
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (pcF !== 32'hBFC00000 || redirectPending !== 1'b0 || isInDelaySlotD !== 1'b0 || pcAddrErrF !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pcF=%h pend=%b ds=%b err=%b, required pcF=bfc00000 others 0",
               pcF, redirectPending, isInDelaySlotD, pcAddrErrF);
    end
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pcF !== 32'hBFC00000 + 32'(i * 4) || pcF !== m_pc) begin
        errors++;
        $display("FAIL free_run_%0d: pcF=%h required %h", i, pcF, 32'hBFC00000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch();
    instrD = {6'b000100, 5'd1, 5'd2, 16'hFFFF};
    pcplus4D = 32'hBFC00010;
    isBranchNeeded = 1;
    step();
    idle_inputs();
    checks++;
    if (pcF !== 32'hBFC0000C || isInDelaySlotD !== 1'b1) begin
      errors++;
      $display("FAIL beq_back: pcF=%h ds=%b, required pcF=bfc0000c ds=1", pcF, isInDelaySlotD);
    end
    step();
    checks++;
    if (pcF !== 32'hBFC00010 || isInDelaySlotD !== 1'b0) begin
      errors++;
      $display("FAIL after_beq: pcF=%h ds=%b, required pcF=bfc00010 ds=0", pcF, isInDelaySlotD);
    end
  endtask

  task automatic test_pending_jal();
    logic [31:0] held;
    held = pcF;
    instrD = {6'b000011, 26'h0000100};
    pcplus4D = 32'hBFC00020;
    stallF = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      instrD = 32'h0;
      pcplus4D = 32'h0;
      checks++;
      if (redirectPending !== 1'b1 || pcF !== held) begin
        errors++;
        $display("FAIL jal_pending_%0d: pend=%b pcF=%h, required pend=1 pcF=%h", i, redirectPending, pcF, held);
      end
    end
    stallF = 0;
    step();
    checks++;
    if (pcF !== 32'hB0000400 || redirectPending !== 1'b0) begin
      errors++;
      $display("FAIL jal_release: pcF=%h pend=%b, required pcF=b0000400 pend=0", pcF, redirectPending);
    end
  endtask

  task automatic test_exc_flush();
    instrD = {6'b000010, 26'h0000200};
    pcplus4D = 32'hBFC00040;
    stallF = 1;
    step();
    idle_inputs();
    checks++;
    if (redirectPending !== 1'b1) begin
      errors++;
      $display("FAIL exc_setup_pend: pend=%b required 1", redirectPending);
    end
    stallF = 1;
    excFlush = 1;
    excPC = 32'hBFC00380;
    step();
    idle_inputs();
    checks++;
    if (pcF !== 32'hBFC00380 || redirectPending !== 1'b0 || isInDelaySlotD !== 1'b0) begin
      errors++;
      $display("FAIL exc_flush: pcF=%h pend=%b ds=%b, required pcF=bfc00380 pend=0 ds=0",
               pcF, redirectPending, isInDelaySlotD);
    end
  endtask

  task automatic test_jr_misaligned();
    instrD = {6'b000000, 5'd4, 15'd0, 6'b001000};
    isJumpToReg = 1;
    rsValueD = 32'h80001002;
    step();
    idle_inputs();
    checks++;
    if (pcF !== 32'h80001002 || pcAddrErrF !== m_err || isInDelaySlotD !== 1'b1) begin
      errors++;
      $display("FAIL jr_target: pcF=%h err=%b ds=%b, required pcF=80001002 err=%b ds=1",
               pcF, pcAddrErrF, isInDelaySlotD, m_err);
    end
    step();
    checks++;
    if (pcF !== 32'h80001006 || pcAddrErrF !== m_err) begin
      errors++;
      $display("FAIL jr_next: pcF=%h err=%b, required pcF=80001006 err=%b", pcF, pcAddrErrF, m_err);
    end
  endtask

  task automatic test_stallD_blocks();
    logic [31:0] p;
    logic        ds;
    do_reset();
    p = pcF;
    ds = isInDelaySlotD;
    stallD = 1;
    isBranchNeeded = 1;
    instrD = {6'b000101, 10'd0, 16'h0010};
    pcplus4D = 32'h00001000;
    step();
    checks++;
    if (pcF !== p + 32'd4 || redirectPending !== 1'b0 || isInDelaySlotD !== ds) begin
      errors++;
      $display("FAIL stallD_no_redirect: pcF=%h pend=%b ds=%b, required pcF=%h pend=0 ds=%b",
               pcF, redirectPending, isInDelaySlotD, p + 32'd4, ds);
    end
    stallF = 1;
    step();
    checks++;
    if (pcF !== p + 32'd4 || redirectPending !== 1'b0) begin
      errors++;
      $display("FAIL stallD_stallF_hold: pcF=%h pend=%b, required pcF=%h pend=0", pcF, redirectPending, p + 32'd4);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_pending();
    instrD = {6'b000011, 26'h0000300};
    pcplus4D = 32'h40000000;
    stallF = 1;
    step();
    idle_inputs();
    do_reset();
    checks++;
    if (pcF !== 32'hBFC00004 || redirectPending !== 1'b0 || pcF !== m_pc) begin
      errors++;
      $display("FAIL reset_discards_pending: pcF=%h pend=%b, required pcF=bfc00004 pend=0", pcF, redirectPending);
    end
    step();
    checks++;
    if (pcF !== 32'hBFC00008) begin
      errors++;
      $display("FAIL post_reset_seq: pcF=%h required bfc00008", pcF);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd1; ops[3] = 6'd2;
    ops[4] = 6'd3; ops[5] = 6'd0; ops[6] = 6'h23; ops[7] = 6'h08;
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      instrD = $urandom;
      instrD[31:26] = op;
      if (op == 6'd0) instrD[5:0] = ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b100001;
      pcplus4D = $urandom & 32'hFFFF_FFFC;
      rsValueD = $urandom;
      if ($urandom_range(0, 3) != 0) rsValueD[1:0] = 2'b00;
      isBranchNeeded = (op == 6'd4 || op == 6'd5 || op == 6'd1) && ($urandom_range(0, 1) != 0);
      isJumpToReg = (op == 6'd0) && (instrD[5:0] == 6'b001000);
      stallF = ($urandom_range(0, 2) == 0);
      stallD = ($urandom_range(0, 4) == 0);
      excFlush = ($urandom_range(0, 15) == 0);
      excPC = $urandom;
      step();
      checks++;
      if (pcF !== m_pc || redirectPending !== (m_q.size() != 0) || isInDelaySlotD !== m_ds || pcAddrErrF !== m_err) begin
        errors++;
        $display("FAIL random_%0d: pcF=%h pend=%b ds=%b err=%b, required pcF=%h pend=%b ds=%b err=%b",
                 n, pcF, redirectPending, isInDelaySlotD, pcAddrErrF,
                 m_pc, (m_q.size() != 0), m_ds, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_branch();
    test_pending_jal();
    test_exc_flush();
    test_jr_misaligned();
    test_stallD_blocks();
    test_reset_mid_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
